frac_ce_gen: RTL and testbench
==============================

# frac_ce_gen

Multi-channel fractional clock-enable synthesiser that replaces fixed-frequency PLL outputs with programmable-rate enables derived from a single fabric clock. Each channel runs a phase accumulator whose carry produces single-cycle `ce_out` pulses at an average rate of `refclk * inc / 2^ACC_W`. The accumulator MSB also provides a near-50% `clk_out` strobe. Rates can be retuned at run time; a PLL-style `locked` indication covers each retune. Sits between the top-level clocking and video/CPU timing logic that needs off-grid rates, e.g. 57.272727 MHz-derived colourburst timing.

## Interface
- `NUM_CH`, 2: number of independent channels, ≥1.
- `ACC_W`, 24: accumulator and increment width in bits, 8..32.
- `LOCK_CYCLES`, 16: cycles `locked` stays low after reset or load, ≥1.
- `DEFAULT_INC`, 24'h800000: increment loaded into every channel on reset, ACC_W bits.

- `refclk`  in  1  sole clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `inc_in`  in  NUM_CH*ACC_W  packed new increments; channel i at bits [i*ACC_W +: ACC_W].
- `phase_in`  in  NUM_CH*ACC_W  packed start phases, same packing; used only with `FRAC_CE_PHASE_EN`.
- `load`  in  1  one-cycle strobe: capture `inc_in` (and `phase_in`) and relock.
- `ce_out`  out  NUM_CH  per-channel enable pulses, registered.
- `clk_out`  out  NUM_CH  per-channel accumulator MSB, registered.
- `locked`  out  1  high when all channels are running at the current increments.

## Operation
- State per channel: `inc_r[ACC_W]`, `acc[ACC_W]`, `ce_r`. Shared: `lock_cnt` ($clog2(LOCK_CYCLES+1) bits), `locked_r`.
- Two states: LOCKING (`locked`=0) and RUN (`locked`=1).
- LOCKING: `acc` held at start value; `ce_out`=0; `lock_cnt` increments each cycle; when `lock_cnt`==LOCK_CYCLES-1, next edge sets `locked`=1 and enters RUN.
- RUN: every edge, `{carry, acc} <= {1'b0,acc} + {1'b0,inc_r}` (ACC_W+1-bit sum, modulo 2^ACC_W wrap); `ce_r <= carry`; `clk_out <= new acc MSB`.
- `load` in any state: next edge latches `inc_r <= inc_in`, sets `acc` to start value, `lock_cnt`=0, `locked`=0, `ce_out`=0, enters LOCKING. A `load` during LOCKING restarts the count.
- Start value: 0, or `phase_in` slice with the macro.
- `inc_r`=0: channel never pulses, `clk_out` constant. `inc_r`=2^ACC_W-1: pulse on all but one cycle in 2^ACC_W.
- Channels are independent except for the shared `load` and `locked`.

## Timing
- Reset (rst=1 at an edge): `inc_r`=DEFAULT_INC all channels, `acc`=0, `lock_cnt`=0, `locked`=0, `ce_out`=0, `clk_out`=0. `rst` wins over simultaneous `load`.
- After `rst` deasserts or `load` at edge E0: `locked` rises at edge E0+LOCK_CYCLES. The first accumulate occurs at edge E0+LOCK_CYCLES+1.
- `ce_out` latency: high for exactly one cycle, following the edge whose sum carried out. No back-to-back merging: consecutive carries give consecutive highs.
- Long-run pulse count over K RUN cycles equals floor((start + K*inc)/2^ACC_W), exact, no drift.
- `inc_in`/`phase_in` are sampled only at the `load` edge; changes at other times are ignored.

## Configuration
- `FRAC_CE_PHASE_EN` defined: `load` also captures the `phase_in` slice as the accumulator start value. After reset the start value is 0. This lets channels run with fixed relative phase.
- Undefined: `phase_in` is ignored (may be left unconnected/tied 0), and the start value is always 0.

## Test plan
- Reset, LOCK_CYCLES=16, defaults: `locked` rises 16 edges after `rst` release. `ce_out[i]` then toggles 0,1,0,1 (period 2), and `clk_out` alternates.
- Load ch0 inc=24'h155555 (≈1/12), ch1 inc=0: exactly 1 pulse per 12 cycles on ch0 over 12000 RUN cycles (1000 pulses ±1). ch1 stays 0.
- `load` mid-RUN: `locked` and `ce_out` drop on the next edge. There are no pulses for 16 cycles, then the new rate is in effect.
- `load` repeated every 8 cycles with LOCK_CYCLES=16: `locked` never rises. Stop loading: `locked` rises 16 edges after the last load.
- `rst` and `load` asserted together with inc_in=0: `inc_r` becomes DEFAULT_INC and `locked` follows the reset timing.
- With `FRAC_CE_PHASE_EN`, both channels inc=2^23, ch1 phase=2^23: ch0 and ch1 pulses alternate cycles, never coincident. Without the macro, the same stimulus gives coincident pulses.

Source files
------------

// File: rtl/frac_ce_gen.sv
// Multi-channel fractional clock-enable generator (phase accumulator per channel); FRAC_CE_PHASE_EN adds loadable start phase.
// Latency: locked rises LOCK_CYCLES edges after rst/load; ce_out/clk_out registered, one edge after the carrying sum.
// Backpressure: none, free-running; inc_in/phase_in sampled only on load.
module frac_ce_gen #(
  parameter int NUM_CH = 2,
  parameter int ACC_W = 24,
  parameter int LOCK_CYCLES = 16,
  parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(24'h800000)
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic [NUM_CH*ACC_W-1:0] inc_in,
  input  logic [NUM_CH*ACC_W-1:0] phase_in,
  input  logic                    load,
  output logic [NUM_CH-1:0]       ce_out,
  output logic [NUM_CH-1:0]       clk_out,
  output logic                    locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic {LOCKING = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state    <= LOCKING;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    case (state)
      LOCKING: begin
        if (lock_cnt == LAST_CNT) begin
          state_nxt = RUN;
        end else begin
          lock_cnt_nxt = lock_cnt + CNT_W'(1);
        end
      end
      RUN: state_nxt = RUN;
      default: state_nxt = LOCKING;
    endcase
    // A load restarts the lock window from any state, including mid-LOCKING.
    if (load) begin
      state_nxt    = LOCKING;
      lock_cnt_nxt = '0;
    end
  end

  assign locked = (state == RUN);

`ifndef FRAC_CE_PHASE_EN
  logic unused_phase;
  assign unused_phase = ^phase_in;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] inc_r;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] start_val;
    logic [ACC_W:0]   sum;
    logic             ce_r;
    logic             clk_r;

`ifdef FRAC_CE_PHASE_EN
    assign start_val = phase_in[i*ACC_W +: ACC_W];
`else
    assign start_val = '0;
`endif

    assign sum = {1'b0, acc} + {1'b0, inc_r};

    always_ff @(posedge refclk) begin
      if (rst) begin
        inc_r <= DEFAULT_INC;
        acc   <= '0;
        ce_r  <= 1'b0;
        clk_r <= 1'b0;
      end else if (load) begin
        inc_r <= inc_in[i*ACC_W +: ACC_W];
        acc   <= start_val;
        ce_r  <= 1'b0;
        clk_r <= 1'b0;
      end else if (state == RUN) begin
        acc   <= sum[ACC_W-1:0];
        ce_r  <= sum[ACC_W];
        clk_r <= sum[ACC_W-1];
      end else begin
        ce_r  <= 1'b0;
      end
    end

    assign ce_out[i]  = ce_r;
    assign clk_out[i] = clk_r;
  end

endmodule

// File: tb/tb_frac_ce_gen.sv
// Directed bench for frac_ce_gen: lock timing, pulse counts per rate, reload and reset corners.
module tb_frac_ce_gen;

  localparam int NUM_CH = 2;
  localparam int ACC_W = 24;
  localparam int L = 16;

  logic        refclk = 1'b0;
  logic        rst;
  logic        load;
  logic [47:0] inc_in;
  logic [47:0] phase_in;
  logic [1:0]  ce_out;
  logic [1:0]  clk_out;
  logic        locked;

  always #5 refclk = ~refclk;

  frac_ce_gen #(
    .NUM_CH(NUM_CH),
    .ACC_W(ACC_W),
    .LOCK_CYCLES(L),
    .DEFAULT_INC(24'h800000)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .inc_in(inc_in),
    .phase_in(phase_in),
    .load(load),
    .ce_out(ce_out),
    .clk_out(clk_out),
    .locked(locked)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Called just after the rst/load edge E0; walks edges E0+1..E0+L.
  task automatic lock_check(input string tag);
    int ce_seen;
    logic lk_pre;
    ce_seen = 0;
    lk_pre = 1'b0;
    for (int k = 1; k <= L; k++) begin
      tick();
      if (ce_out != 2'b00) ce_seen++;
      if (k == 1) chk({tag, " locked_drop"}, {31'd0, locked}, 32'd0);
      if (k == L - 1) lk_pre = locked;
    end
    chk({tag, " locked_early"}, {31'd0, lk_pre}, 32'd0);
    chk({tag, " locked_rise"}, {31'd0, locked}, 32'd1);
    chk({tag, " ce_during_lock"}, ce_seen, 0);
  endtask

  task automatic do_load(input logic [23:0] i0, input logic [23:0] i1,
                         input logic [23:0] p0, input logic [23:0] p1);
    inc_in   = {i1, i0};
    phase_in = {p1, p0};
    load     = 1'b1;
    tick();
    load     = 1'b0;
    // Later changes must be ignored until the next load.
    inc_in   = 48'hA5A5A5_5A5A5A;
    phase_in = 48'h123456_654321;
  endtask

  typedef struct {
    logic [23:0] inc0;
    logic [23:0] inc1;
    int          k;
    int          exp0;
    int          exp1;
  } vec_t;

  vec_t vt[5];

  initial begin
    int c0, c1, both;
    logic lk_seen;

    vt[0] = '{24'h800000, 24'h800000, 100, 50, 50};
    vt[1] = '{24'h155555, 24'h000000, 12000, 999, 0};
    vt[2] = '{24'hFFFFFF, 24'h000001, 256, 255, 0};
    vt[3] = '{24'h400000, 24'hC00000, 64, 16, 48};
    vt[4] = '{24'h123456, 24'h0ABCDE, 1000, 71, 41};

    rst = 1'b1;
    load = 1'b0;
    inc_in = '0;
    phase_in = '0;
    repeat (3) tick();
    chk("rst locked", {31'd0, locked}, 32'd0);
    chk("rst ce", {30'd0, ce_out}, 32'd0);
    chk("rst clk", {30'd0, clk_out}, 32'd0);

    rst = 1'b0;
    lock_check("reset");
    for (int j = 0; j < 8; j++) begin
      tick();
      chk($sformatf("dflt ce[%0d]", j), {30'd0, ce_out}, (j % 2 == 1) ? 32'd3 : 32'd0);
      chk($sformatf("dflt clk[%0d]", j), {30'd0, clk_out}, (j % 2 == 0) ? 32'd3 : 32'd0);
    end

    // Each vector loads from RUN, so it also covers mid-run reload.
    for (int v = 0; v < 5; v++) begin
      do_load(vt[v].inc0, vt[v].inc1, 24'h0, 24'h0);
      lock_check($sformatf("vec%0d", v));
      c0 = 0;
      c1 = 0;
      for (int k = 0; k < vt[v].k; k++) begin
        tick();
        c0 += int'(ce_out[0]);
        c1 += int'(ce_out[1]);
      end
      chk($sformatf("vec%0d ch0 pulses", v), c0, vt[v].exp0);
      chk($sformatf("vec%0d ch1 pulses", v), c1, vt[v].exp1);
    end

    // Reload every 8 cycles: lock never achieved.
    lk_seen = 1'b0;
    for (int r = 0; r < 5; r++) begin
      do_load(24'h400000, 24'h400000, 24'h0, 24'h0);
      for (int k = 0; k < 7; k++) begin
        tick();
        lk_seen |= locked;
      end
    end
    chk("reload locked_seen", {31'd0, lk_seen}, 32'd0);
    do_load(24'h400000, 24'h400000, 24'h0, 24'h0);
    lock_check("reload_last");

    // Reset beats a simultaneous load of inc 0.
    rst = 1'b1;
    load = 1'b1;
    inc_in = '0;
    tick();
    rst = 1'b0;
    load = 1'b0;
    lock_check("rst_load");
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      c0 += int'(ce_out[0]);
      c1 += int'(ce_out[1]);
    end
    chk("rst_load ch0 pulses", c0, 10);
    chk("rst_load ch1 pulses", c1, 10);

    // Relative phase of half a cycle on ch1.
    do_load(24'h800000, 24'h800000, 24'h000000, 24'h800000);
    lock_check("phase");
    c0 = 0;
    c1 = 0;
    both = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      c0 += int'(ce_out[0]);
      c1 += int'(ce_out[1]);
      if (ce_out == 2'b11) both++;
    end
    chk("phase ch0 pulses", c0, 10);
    chk("phase ch1 pulses", c1, 10);
`ifdef FRAC_CE_PHASE_EN
    chk("phase coincident", both, 0);
`else
    chk("phase coincident", both, 10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
